// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: N masters, registered one-hot req/ack handshake, fixed-priority or
// round-robin selection, optional hold-time revocation and a one-cycle release gap.
module bus_arbiter #(
  parameter int unsigned NUM_DEVICES = 8,
  parameter int unsigned D_WIDTH     = 32,
  parameter int unsigned C_WIDTH     = 8,
  parameter int unsigned MODE        = 0,
  parameter int unsigned MAX_HOLD    = 0,
  parameter int unsigned ID_WIDTH    = 3
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic [NUM_DEVICES-1:0]         req,
  input  logic [NUM_DEVICES*D_WIDTH-1:0] bus_in,
  input  logic [NUM_DEVICES*C_WIDTH-1:0] ctrl_in,
  output logic [NUM_DEVICES-1:0]         ack,
  output logic [D_WIDTH-1:0]             bus_out,
  output logic [C_WIDTH-1:0]             ctrl_out,
  output logic [ID_WIDTH-1:0]            grant_id,
  output logic                           busy,
  output logic                           timeout
);

  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e                  state_q, state_d;
  logic [NUM_DEVICES-1:0]  ack_q, ack_d;
  logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [HoldW-1:0]        hold_q, hold_d;
  logic                    timeout_q, timeout_d;

  logic [ID_WIDTH-1:0]     winner, win_hi, win_lo;
  logic                    found_hi, found_lo;
  logic [HoldW:0]          hold_inc;
  logic                    owner_req, others_pending;

  // Round-robin: first requester above the pointer, else wrap to the lowest requester.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    winner   = '0;
    for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
      if (req[i]) begin
        if (MODE == 0) begin
          winner = ID_WIDTH'(i);
        end else begin
          if (!found_hi && (ID_WIDTH'(i) > ptr_q)) begin
            win_hi   = ID_WIDTH'(i);
            found_hi = 1'b1;
          end
          if (!found_lo) begin
            win_lo   = ID_WIDTH'(i);
            found_lo = 1'b1;
          end
        end
      end
    end
    if (MODE != 0) begin
      winner = found_hi ? win_hi : win_lo;
    end
  end

  assign owner_req      = |(req & ack_q);
  assign others_pending = |(req & ~ack_q);
  assign hold_inc       = {1'b0, hold_q} + (HoldW + 1)'(1);

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d    = StGrant;
          grant_id_d = winner;
          hold_d     = '0;
          for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
            ack_d[i] = (winner == ID_WIDTH'(i));
          end
          if (MODE != 0) begin
            ptr_d = winner;
          end
        end
      end
      StGrant: begin
        // A voluntary release takes precedence over a coincident hold-limit revocation.
        if (!owner_req) begin
          state_d = StRelease;
          ack_d   = '0;
          hold_d  = '0;
        end else if (others_pending) begin
          if ((MAX_HOLD != 0) && (hold_inc == (HoldW + 1)'(MAX_HOLD))) begin
            state_d   = StRelease;
            ack_d     = '0;
            hold_d    = '0;
            timeout_d = 1'b1;
          end else begin
            hold_d = hold_inc[HoldW-1:0];
          end
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        ack_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= StIdle;
      ack_q      <= '0;
      grant_id_q <= '0;
      ptr_q      <= ID_WIDTH'(NUM_DEVICES - 1);
      hold_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ack      = ack_q;
  assign busy     = |ack_q;
  assign grant_id = grant_id_q;
  assign timeout  = timeout_q;

  always_comb begin
    bus_out  = '0;
    ctrl_out = '0;
    for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
      if (busy && (grant_id_q == ID_WIDTH'(i))) begin
        bus_out  = bus_in[i*D_WIDTH +: D_WIDTH];
        ctrl_out = ctrl_in[i*C_WIDTH +: C_WIDTH];
      end
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised successor to the system bus controller: arbitrates N bus masters over one shared data/control bus with a registered one-hot req/ack handshake.
- Selectable fixed-priority or round-robin policy, optional hold-time limit with forced revocation, one-cycle bus turnaround.
- Sits between all bus devices (RAM controller, ROM, VGA, PS/2, audio copper, CPU) and drives the shared bus_out/ctrl_out seen by every device.

Parameters:
- NUM_DEVICES, 8, number of masters/ports; device ID = port index; ≥2.
- D_WIDTH, 32, data width per device.
- C_WIDTH, 8, control width per device.
- MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.
- MAX_HOLD, 0, max consecutive ack cycles while another req pends; 0 disables the limit.
- ID_WIDTH, 3, width of grant_id; must be ≥ clog2(NUM_DEVICES).

Ports:
- clk  in  1  system clock.
- reset_L  in  1  asynchronous active-low reset.
- req  in  NUM_DEVICES  per-device bus request, level-held.
- bus_in  in  NUM_DEVICES*D_WIDTH  packed data; device k occupies [k*D_WIDTH +: D_WIDTH].
- ctrl_in  in  NUM_DEVICES*C_WIDTH  packed control; device k occupies [k*C_WIDTH +: C_WIDTH].
- ack  out  NUM_DEVICES  one-hot grant, registered.
- bus_out  out  D_WIDTH  shared data bus.
- ctrl_out  out  C_WIDTH  shared control bus.
- grant_id  out  ID_WIDTH  index of current owner; valid while busy.
- busy  out  1  high while any ack is high.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async, reset_L=0): state IDLE; ack=0, busy=0, timeout=0, grant_id=0, hold counter=0, RR pointer=NUM_DEVICES-1. bus_out/ctrl_out=0 throughout reset.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - any req bit set at edge n → winner chosen, ack[winner]=1, busy=1, grant_id=winner from edge n (visible cycle n+1); state GRANT.
  - Latency: req seen → ack 1 cycle.
  - No req → stay IDLE.
- Arbitration:
  - MODE 0: highest set index wins.
  - MODE 1: search from (ptr+1) mod NUM_DEVICES upward with wrap; first set bit wins; ptr ← winner on grant.
  - Lone requester always wins in either mode.
- GRANT:
  - ack held while req[grant_id]=1.
  - Owner deasserts req → ack cleared next edge, state RELEASE; owner's current-cycle bus_in still driven that cycle.
  - Hold counter increments each GRANT cycle while any other req bit is set, and holds its value otherwise.
  - Counter reaches MAX_HOLD (MAX_HOLD>0) → ack cleared, timeout=1 for one cycle, state RELEASE, counter=0.
  - Requests from non-owners are ignored (no preemption) except via timeout.
- RELEASE:
  - Exactly one cycle: ack=0, busy=0, bus_out/ctrl_out=0; then IDLE.
  - A revoked master still asserting req re-competes normally. In MODE 0 it may win again; in MODE 1 it is last in order.
- Bus mux:
  - bus_out = bus_in slice of grant_id when busy, else 0. ctrl_out likewise.
  - Combinational from registered grant; no data latency.
- Width rules: only indices < NUM_DEVICES are used; grant_id zero-extended to ID_WIDTH.
- Simultaneous events:
  - Owner drops req on the same edge the timeout fires → treat as normal release; timeout stays 0.
  - New req in RELEASE cycle → sampled at the IDLE edge that follows.
- ack is one-hot or zero at all times; never two bits high.
- Reset mid-grant: ack drops immediately (async); bus returns to 0.

Test Plan:
- Reset: reset_L=0 while req=8'hFF → ack=0, busy=0, bus_out=0, timeout=0. Release reset_L, req=8'h81, MODE 0 → next cycle ack=8'h80, grant_id=7, bus_out=bus_in[7].
- Handshake/latency: MODE 0, req[0] raised at cycle 5 → ack[0] at cycle 6. Drop req[0] at cycle 10 → ack=0 at cycle 11, RELEASE, IDLE at 12.
- Round-robin: MODE 1, req=8'h0D held; each owner drops req after 2 ack cycles and reasserts → grant order 0,2,3,0,2,3; one idle cycle between grants.
- Timeout: MAX_HOLD=4, req[7] held, req[1] raised one cycle after ack[7] → after 4 counted cycles ack[7] drops, timeout pulses once, then ack[1] (MODE 1) two cycles later.
- Simultaneous drop/timeout: owner releases on the exact MAX_HOLD edge → timeout stays 0, normal RELEASE.
- Async reset during GRANT with ack=8'h04 → ack, busy, bus_out go 0 without waiting for a clock edge; after release, RR pointer restarts at device 0.
